fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the five-stage MIPS pipeline. Sits directly upstream of the asynchronous instruction ROM and downstream of decode/writeback redirect buses.
- Holds the PC and drives the ROM word address. Combines the returned instruction with its PC into the IF→ID bus using the valid/allowin pipeline handshake.
- Handles branch delay slots, pending redirects under stall, and exception/ERET redirects.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_stage_pc_next_sel.sv | 24 ++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: bus widths, reset and
// exception vectors, and the IF stage control-state encoding.
package cpu_pkg;

  localparam int unsigned PC_W        = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned BR_BUS_W    = 33;
  localparam int unsigned EXC_BUS_W   = 33;
  localparam int unsigned IF_ID_BUS_W = 64;

  localparam logic [PC_W-1:0] RESET_PC  = 32'h0000_0034;
  // Handler entry; the WB stage supplies the real target on exc_bus.
  localparam logic [PC_W-1:0] EXC_ENTRY = 32'h0000_0000;

  // Encoding is {if_valid, br_pend}.
  typedef enum logic [1:0] {
    IF_RESET      = 2'b00,
    IF_FETCH      = 2'b10,
    IF_FETCH_PEND = 2'b11
  } if_state_e;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC priority select: exception/ERET redirect, then pending branch
// target, then sequential pc + 4 (32-bit wrap).
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic            exc_valid_i,
  input  logic [PC_W-1:0] exc_target_i,
  input  logic            br_pend_i,
  input  logic [PC_W-1:0] br_tgt_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] next_pc_o
);

  // Fixed priority mux over the three redirect sources.
  always_comb begin
    next_pc_o = pc_i + 32'd4;
    if (exc_valid_i) begin
      next_pc_o = exc_target_i;
    end else if (br_pend_i) begin
      next_pc_o = br_tgt_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, addresses the asynchronous ROM and
// hands {pc, inst} to ID under the valid/allowin handshake. Handles delay
// slots, branches taken under stall and exception/ERET redirects.
// Optional macro FETCH_ADEF_EN: flag misaligned / out-of-range fetch
// addresses on if_adef and replace the instruction with a NOP.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int unsigned     ROM_AW   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ROM_AW-1:0]      inst_addr,
  input  logic [INST_W-1:0]      inst,
  input  logic                   id_allowin,
  input  logic [BR_BUS_W-1:0]    br_bus,
  input  logic [EXC_BUS_W-1:0]   exc_bus,
  output logic                   if_over,
  output logic [IF_ID_BUS_W-1:0] if_id_bus,
  output logic                   if_adef,
  output logic [PC_W-1:0]        if_pc
);

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_tgt_q, br_tgt_d;
  logic [PC_W-1:0] next_pc;

  logic            exc_valid;
  logic [PC_W-1:0] exc_target;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            if_valid;
  logic            br_pend;
  logic            adv;
  logic            pend_eff;
  logic [PC_W-1:0] tgt_eff;

  assign exc_valid  = exc_bus[32];
  assign exc_target = exc_bus[31:0];
  // An exception in the same cycle overrides any branch from ID.
  assign br_taken   = br_bus[32] & ~exc_valid;
  assign br_target  = br_bus[31:0];

  assign if_valid = (state_q != IF_RESET);
  assign br_pend  = (state_q == IF_FETCH_PEND);
  assign adv      = if_over & id_allowin;

  // A branch arriving while the delay slot advances is consumed directly so
  // the sequential successor of the delay slot is never fetched; a branch
  // arriving under stall is latched and used once the delay slot advances.
  assign pend_eff = br_pend | br_taken;
  assign tgt_eff  = br_taken ? br_target : br_tgt_q;

  pc_next_sel u_pc_next_sel (
    .exc_valid_i  (exc_valid),
    .exc_target_i (exc_target),
    .br_pend_i    (pend_eff),
    .br_tgt_i     (tgt_eff),
    .pc_i         (pc_q),
    .next_pc_o    (next_pc)
  );

  // State register plus PC and latched branch target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IF_RESET;
      pc_q     <= RESET_PC;
      br_tgt_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      br_tgt_q <= br_tgt_d;
    end
  end

  // Next-state and datapath update: redirect on exception, advance on handshake.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    br_tgt_d = br_tgt_q;
    if (exc_valid || adv) begin
      pc_d = next_pc;
    end
    if (br_taken) begin
      br_tgt_d = br_target;
    end
    unique case (state_q)
      IF_RESET: state_d = IF_FETCH;
      IF_FETCH, IF_FETCH_PEND: begin
        if (exc_valid || adv) begin
          state_d = IF_FETCH;
        end else if (br_taken) begin
          state_d = IF_FETCH_PEND;
        end
      end
      default: state_d = IF_RESET;
    endcase
  end

  // Outputs: handshake valid, address-error flag and the IF->ID bus.
  always_comb begin
    if_over   = if_valid & ~exc_valid & ~rst;
    inst_addr = pc_q[ROM_AW+1:2];
    if_pc     = pc_q;
`ifdef FETCH_ADEF_EN
    if_adef   = if_valid & ~rst &
                ((pc_q[1:0] != 2'b00) | (pc_q[PC_W-1:ROM_AW+2] != '0));
    if_id_bus = {pc_q, (if_adef ? '0 : inst)};
`else
    if_adef   = 1'b0;
    if_id_bus = {pc_q, inst};
`endif
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Each vector drives one cycle
// of inputs and states the outputs expected during that cycle.
module tb_fetch_stage;

`ifdef FETCH_ADEF_EN
  localparam bit ADEF_ON = 1'b1;
`else
  localparam bit ADEF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inst_addr;
  logic [31:0] inst;
  logic        id_allowin;
  logic [32:0] br_bus;
  logic [32:0] exc_bus;
  logic        if_over;
  logic [63:0] if_id_bus;
  logic        if_adef;
  logic [31:0] if_pc;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic        rst;
    logic        al;
    logic        br;
    logic [31:0] bt;
    logic        exc;
    logic [31:0] et;
    logic        over;
    logic [31:0] pc;
    logic        adef;
    logic        chk_pc;
  } vec_t;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {16'hBEEF, 8'h00, a};
  endfunction

  assign inst = rom(inst_addr);

  fetch_stage #(
    .RESET_PC (32'h0000_0034),
    .ROM_AW   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .id_allowin (id_allowin),
    .br_bus     (br_bus),
    .exc_bus    (exc_bus),
    .if_over    (if_over),
    .if_id_bus  (if_id_bus),
    .if_adef    (if_adef),
    .if_pc      (if_pc)
  );

  function automatic vec_t v(input logic r, input logic al, input logic br,
                             input logic [31:0] bt, input logic exc,
                             input logic [31:0] et, input logic over,
                             input logic [31:0] pc, input logic adef,
                             input logic chk_pc);
    vec_t t;
    t.rst = r; t.al = al; t.br = br; t.bt = bt; t.exc = exc; t.et = et;
    t.over = over; t.pc = pc; t.adef = adef; t.chk_pc = chk_pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h want %h", n_vec, name, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    logic [7:0]  ea;
    logic        eadef;
    logic [31:0] einst;
    @(negedge clk);
    rst        = t.rst;
    id_allowin = t.al;
    br_bus     = {t.br, t.bt};
    exc_bus    = {t.exc, t.et};
    #1;
    ea    = t.pc[9:2];
    eadef = t.adef & ADEF_ON;
    einst = eadef ? 32'h0 : rom(ea);
    chk("if_over", 64'(if_over), 64'(t.over));
    chk("if_adef", 64'(if_adef), 64'(eadef));
    if (t.chk_pc) begin
      chk("if_pc",     64'(if_pc),            64'(t.pc));
      chk("inst_addr", 64'(inst_addr),        64'(ea));
      chk("bus_pc",    64'(if_id_bus[63:32]), 64'(t.pc));
      chk("bus_inst",  64'(if_id_bus[31:0]),  64'(einst));
    end
    n_vec++;
  endtask

  vec_t tbl[25];

  initial begin
    // Reset, sequential fetch, 3-cycle stall, branch without and with stall.
    tbl[0]  = v(1, 1, 0, 0,     0, 0, 0, 32'h34,  0, 1);
    tbl[1]  = v(0, 1, 0, 0,     0, 0, 0, 32'h34,  0, 1);
    tbl[2]  = v(0, 1, 0, 0,     0, 0, 1, 32'h34,  0, 1);
    tbl[3]  = v(0, 1, 0, 0,     0, 0, 1, 32'h38,  0, 1);
    tbl[4]  = v(0, 1, 0, 0,     0, 0, 1, 32'h3C,  0, 1);
    tbl[5]  = v(0, 1, 0, 0,     0, 0, 1, 32'h40,  0, 1);
    tbl[6]  = v(0, 0, 0, 0,     0, 0, 1, 32'h44,  0, 1);
    tbl[7]  = v(0, 0, 0, 0,     0, 0, 1, 32'h44,  0, 1);
    tbl[8]  = v(0, 0, 0, 0,     0, 0, 1, 32'h44,  0, 1);
    tbl[9]  = v(0, 1, 0, 0,     0, 0, 1, 32'h44,  0, 1);
    tbl[10] = v(0, 1, 0, 0,     0, 0, 1, 32'h48,  0, 1);
    tbl[11] = v(0, 1, 0, 0,     0, 0, 1, 32'h4C,  0, 1);
    tbl[12] = v(0, 1, 0, 0,     0, 0, 1, 32'h50,  0, 1);
    tbl[13] = v(0, 1, 0, 0,     0, 0, 1, 32'h54,  0, 1);
    tbl[14] = v(0, 1, 0, 0,     0, 0, 1, 32'h58,  0, 1);
    tbl[15] = v(0, 1, 0, 0,     0, 0, 1, 32'h5C,  0, 1);
    tbl[16] = v(0, 1, 0, 0,     0, 0, 1, 32'h60,  0, 1);
    tbl[17] = v(0, 1, 1, 32'h6C, 0, 0, 1, 32'h64, 0, 1);
    tbl[18] = v(0, 1, 0, 0,     0, 0, 1, 32'h6C,  0, 1);
    tbl[19] = v(0, 1, 0, 0,     0, 0, 1, 32'h70,  0, 1);
    tbl[20] = v(0, 0, 1, 32'h100, 0, 0, 1, 32'h74, 0, 1);
    tbl[21] = v(0, 0, 0, 0,     0, 0, 1, 32'h74,  0, 1);
    tbl[22] = v(0, 1, 0, 0,     0, 0, 1, 32'h74,  0, 1);
    tbl[23] = v(0, 1, 0, 0,     0, 0, 1, 32'h100, 0, 1);
    tbl[24] = v(0, 1, 0, 0,     0, 0, 1, 32'h104, 0, 1);

    rst = 1'b1; id_allowin = 1'b1; br_bus = '0; exc_bus = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) run(tbl[i]);

    // Exception while stalled with a pending branch, then ERET to 0x4C.
    run(v(0, 0, 1, 32'h200, 0, 0,       1, 32'h108, 0, 1));
    run(v(0, 0, 0, 0,       1, 0,       0, 32'h108, 0, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'h0,   0, 1));
    run(v(0, 1, 0, 0,       1, 32'h4C,  0, 32'h4,   0, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'h4C,  0, 1));
    // Exception and branch together: exception wins, lands at 0x1B4.
    run(v(0, 1, 1, 32'h300, 1, 32'h1B4, 0, 32'h50,  0, 1));
    // Latch a branch under stall, then reset mid-run.
    run(v(0, 0, 1, 32'h80,  0, 0,       1, 32'h1B4, 0, 1));
    run(v(1, 0, 0, 0,       0, 0,       0, 32'h1B4, 0, 0));
    run(v(0, 1, 0, 0,       0, 0,       0, 32'h34,  0, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'h34,  0, 1));
    // Pending branch was discarded by reset: sequential 0x38, not 0x80.
    run(v(0, 1, 0, 0,       1, 32'h3E,  0, 32'h38,  0, 1));
    // Misaligned and out-of-range fetch addresses, then 32-bit wrap.
    run(v(0, 0, 0, 0,       1, 32'h400, 0, 32'h3E,  1, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'h400, 1, 1));
    run(v(0, 1, 0, 0,       1, 32'hFFFF_FFFC, 0, 32'h404, 1, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'hFFFF_FFFC, 1, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'h0,   0, 1));
    run(v(0, 1, 0, 0,       0, 0,       1, 32'h4,   0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
